// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered single-issue ALU with an iterative shift-add
// multiplier (DATA_W cycles) or, when ALU_FAST_MUL_EN is defined, a
// combinational multiplier with the same latency as the other operations.
//
// Handshake: an operation is accepted on a rising edge where in_valid and
// in_ready are both high; in_ready is high exactly while the FSM is IDLE and
// in_valid is ignored otherwise. out_valid pulses for one cycle per result,
// and a new op may be accepted in that same cycle.
module alu_exec_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        aluopcode,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              out_valid,
  output logic              state_dbg   // 0 = IDLE, 1 = MUL_RUN
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b10000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLT  = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_MUL  = 5'b01001;

  typedef enum logic {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] mcand, mplier, acc, acc_step;
  logic [CNT_W-1:0]  cnt;
  logic              accept, start_mul, single_done, mul_last;

  assign in_ready  = (state == IDLE);
  assign state_dbg = state;
  assign accept    = in_valid && in_ready;

`ifdef ALU_FAST_MUL_EN
  assign start_mul = 1'b0;
`else
  assign start_mul = accept && (aluopcode == OP_MUL);
`endif

  assign single_done = accept && !start_mul;
  assign mul_last    = (state == MUL_RUN) && (cnt == '0);
  assign acc_step    = acc + (mplier[0] ? mcand : '0);

  // Single-cycle operation result; unknown opcodes give 0.
  always_comb begin
    alu_res = '0;
    case (aluopcode)
      OP_ADD:  alu_res = operand_a + operand_b;
      OP_SUB:  alu_res = operand_a - operand_b;
      OP_SLL:  alu_res = operand_a << operand_b[SH_W-1:0];
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (operand_a < operand_b)};
      OP_XOR:  alu_res = operand_a ^ operand_b;
      OP_SRL:  alu_res = operand_a >> operand_b[SH_W-1:0];
      OP_OR:   alu_res = operand_a | operand_b;
      OP_AND:  alu_res = operand_a & operand_b;
`ifdef ALU_FAST_MUL_EN
      OP_MUL:  alu_res = operand_a * operand_b;
`endif
      default: alu_res = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state: a multiply runs until the counter reaches zero.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_mul) state_next = MUL_RUN;
      MUL_RUN: if (cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: multiplier iteration plus result/zero/out_valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (start_mul) begin
        mcand  <= operand_a;
        mplier <= operand_b;
        cnt    <= CNT_W'(DATA_W - 1);
        acc    <= '0;
      end else if (state == MUL_RUN) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (cnt != '0) cnt <= cnt - 1'b1;
        if (mul_last) begin
          result    <= acc_step;
          zero      <= (acc_step == '0);
          out_valid <= 1'b1;
        end
      end
      if (single_done) begin
        result    <= alu_res;
        zero      <= (alu_res == '0);
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving operand and result width; all cycle counts below are stated for DATA_W=32.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all flops SHALL be rising-edge triggered.
REQ-003 The block SHALL have input rst, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have input in_valid, 1 bit, meaning an operation is offered.
REQ-005 The block SHALL have output in_ready, 1 bit, meaning an operation can be accepted this cycle.
REQ-006 The block SHALL have input aluopcode, 5 bits, the operation code from the ALU-control stage.
REQ-007 The block SHALL have inputs operand_a and operand_b, DATA_W bits each, the source operands.
REQ-008 The block SHALL have output result, DATA_W bits, the registered result.
REQ-009 The block SHALL have output zero, 1 bit, registered, high when result equals 0.
REQ-010 The block SHALL have output out_valid, 1 bit, a one-cycle pulse marking a new result.

Function
REQ-011 Accept SHALL occur on a rising edge where in_valid and in_ready are both high; in_valid is ignored while in_ready is low.
REQ-012 Opcode map:
- 00000 ADD
- 10000 SUB (a-b)
- 00001 SLL (a<<b[4:0])
- 00010 SLT signed
- 00011 SLTU
- 00100 XOR
- 00101 SRL logical
- 00110 OR
- 00111 AND
- 01001 MUL (low DATA_W bits of a*b)
REQ-013 Any other opcode SHALL produce result 0 and zero 1, with single-op latency.
REQ-014 Arithmetic SHALL wrap modulo 2^DATA_W; SLT/SLTU SHALL yield 1 or 0, zero-extended.
REQ-015 FSM states SHALL be IDLE and MUL_RUN; in_ready SHALL be high exactly when the state is IDLE.
REQ-016 A non-MUL op accepted at edge N SHALL update result and zero and pulse out_valid for the cycle after edge N; the state SHALL stay IDLE.
REQ-017 A MUL accepted at edge N SHALL latch the operands, load the iteration counter with 31, clear the accumulator and enter MUL_RUN.
REQ-018 In MUL_RUN, each edge SHALL add the shifted multiplicand to the accumulator if the multiplier LSB is 1, shift both, and decrement the counter.
REQ-019 On the MUL_RUN edge where the counter is 0 (edge N+32), the block SHALL write result and zero, pulse out_valid and return to IDLE.
REQ-020 A new op MAY be accepted in the same cycle out_valid is high (back-to-back issue).
REQ-021 Operand or opcode changes during MUL_RUN SHALL NOT affect the result.
REQ-022 result and zero SHALL hold their last value until the next completion.

Reset
REQ-023 When rst is asserted, the block SHALL immediately set:
- state IDLE
- result 0
- zero 1
- out_valid 0
- counter 0
- accumulator 0
REQ-024 Reset during MUL_RUN SHALL abort the multiply with no out_valid pulse.
REQ-025 After rst deasserts, in_ready SHALL be high in the first cycle.

Configuration
REQ-026 Macro ALU_FAST_MUL_EN SHALL select the MUL implementation.
REQ-027 With ALU_FAST_MUL_EN defined, MUL SHALL use a combinational multiplier, have single-op latency per REQ-016, and never enter MUL_RUN.
REQ-028 Without ALU_FAST_MUL_EN, MUL SHALL be the iterative 32-cycle behaviour per REQ-017 to REQ-019.
REQ-029 All non-MUL behaviour SHALL be identical with and without ALU_FAST_MUL_EN.

Verification
REQ-030 ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, zero 0, out_valid one cycle after accept; SUB a=5, b=5 -> result 0, zero 1.
REQ-031 SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0; SLL a=1, b=0x23 -> 0x8.
REQ-032 MUL a=0xFFFFFFFF, b=3, default build -> in_ready low for 32 cycles, result 0xFFFFFFFD, out_valid after edge N+32; with ALU_FAST_MUL_EN -> out_valid after edge N+1.
REQ-033 MUL in progress with in_valid held high and operands toggled -> no extra accept, result unchanged; a new ADD accepted in the out_valid cycle completes on the next cycle.
REQ-034 rst asserted at cycle 10 of MUL 6*7 -> no out_valid, result 0, zero 1, in_ready high after release.
REQ-035 Opcode 11111 with a=3, b=4 -> result 0, zero 1, out_valid one cycle after accept.
